// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow sequencer for Pong.
//   Sits between the VGA timing generator and the physics block. Turns each
//   rising edge of vert_blank into a frame tick, issues one physics step per
//   frame while in play, scores wall-pass events, runs the serve / point
//   freeze delays, pause/resume and game-over, and pulses ball respawn.
// Ports:
//   clk_25MHz    in   pixel clock, the only clock
//   reset        in   asynchronous active-high reset
//   vert_blank   in   VGA vertical blanking (synchronous)
//   start_btn    in   raw push button (asynchronous): start / pause / restart
//   pass_left    in   1-cycle pulse, ball passed left wall (point to player 1)
//   pass_right   in   1-cycle pulse, ball passed right wall (point to player 0)
//   phys_step    out  1-cycle pulse, physics advances one frame
//   ball_respawn out  1-cycle pulse, physics recentres the ball
//   serve_dir    out  initial ball x direction; 1 = right, 0 = left
//   score0       out  player 0 score
//   score1       out  player 1 score
//   game_state   out  IDLE=0 SERVE=1 PLAY=2 POINT=3 PAUSED=4 OVER=5
//   winner       out  valid in OVER; 0 = player 0, 1 = player 1
module pong_game_ctrl #(
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned POINT_FRAMES = 30,
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned SCORE_W      = 4
) (
   input  logic               clk_25MHz,
   input  logic               reset,
   input  logic               vert_blank,
   input  logic               start_btn,
   input  logic               pass_left,
   input  logic               pass_right,
   output logic               phys_step,
   output logic               ball_respawn,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1,
   output logic [2:0]         game_state,
   output logic               winner
);

   localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

   localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SERVE  = 3'd1,
      PLAY   = 3'd2,
      POINT  = 3'd3,
      PAUSED = 3'd4,
      OVER   = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic             btn_sync1, btn_sync2, btn_prev, btn_press;
   logic             vb_prev, frame_tick;
   logic [CNT_W-1:0] frame_cnt, cnt_nxt;
   logic             pass_r_only, pass_l_only;
   logic             serve_done, point_done, game_won;

   logic               phys_nxt, respawn_nxt, dir_nxt, winner_nxt;
   logic [SCORE_W-1:0] score0_nxt, score1_nxt;

   // Button synchroniser and rising-edge detect; frame tick edge detect.
   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         btn_sync1  <= 1'b0;
         btn_sync2  <= 1'b0;
         btn_prev   <= 1'b0;
         vb_prev    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         btn_sync1  <= start_btn;
         btn_sync2  <= btn_sync1;
         btn_prev   <= btn_sync2;
         vb_prev    <= vert_blank;
         frame_tick <= vert_blank & ~vb_prev;
      end
   end

   assign btn_press   = btn_sync2 & ~btn_prev;
   assign pass_r_only = pass_right & ~pass_left;
   assign pass_l_only = pass_left & ~pass_right;
   assign serve_done  = frame_tick && (frame_cnt == SERVE_LAST);
   assign point_done  = frame_tick && (frame_cnt == POINT_LAST);
   assign game_won    = (score0 == WIN) || (score1 == WIN);

   // State register
   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; a wall pass takes priority over a button press in PLAY.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (btn_press) state_nxt = SERVE;
         SERVE:  if (serve_done) state_nxt = PLAY;
         PLAY: begin
            if (pass_r_only || pass_l_only) state_nxt = POINT;
            else if (btn_press)             state_nxt = PAUSED;
         end
         POINT:  if (point_done) state_nxt = game_won ? OVER : SERVE;
         PAUSED: if (btn_press) state_nxt = PLAY;
         OVER:   if (btn_press) state_nxt = SERVE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs and frame counter.
   always_comb begin
      phys_nxt    = frame_tick && (state == PLAY);
      respawn_nxt = (state_nxt == SERVE) && (state != SERVE);
      score0_nxt  = score0;
      score1_nxt  = score1;
      dir_nxt     = serve_dir;
      winner_nxt  = winner;
      cnt_nxt     = frame_cnt;

      if (state_nxt != state)
         cnt_nxt = '0;
      else if (frame_tick && (state == SERVE || state == POINT))
         cnt_nxt = frame_cnt + 1'b1;

      case (state)
         IDLE, OVER: begin
            if (btn_press) begin
               score0_nxt = '0;
               score1_nxt = '0;
               winner_nxt = 1'b0;
               dir_nxt    = 1'b1;
            end
         end
         PLAY: begin
            if (pass_r_only && score0 != WIN) begin
               score0_nxt = score0 + 1'b1;
               dir_nxt    = 1'b0;
            end else if (pass_l_only && score1 != WIN) begin
               score1_nxt = score1 + 1'b1;
               dir_nxt    = 1'b1;
            end
         end
         POINT: begin
            if (point_done && game_won) winner_nxt = (score1 == WIN);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         phys_step    <= 1'b0;
         ball_respawn <= 1'b0;
         serve_dir    <= 1'b1;
         winner       <= 1'b0;
         score0       <= '0;
         score1       <= '0;
         frame_cnt    <= '0;
      end else begin
         phys_step    <= phys_nxt;
         ball_respawn <= respawn_nxt;
         serve_dir    <= dir_nxt;
         winner       <= winner_nxt;
         score0       <= score0_nxt;
         score1       <= score1_nxt;
         frame_cnt    <= cnt_nxt;
      end
   end

   assign game_state = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

   localparam int SERVE_N = 60;
   localparam int POINT_N = 30;
   localparam int WIN_N   = 7;

   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_PAUSED = 4, S_OVER = 5;
   localparam int EV_STATE = 0, EV_RESPAWN = 1, EV_STEP = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vert_blank = 1'b0;
   logic       start_btn = 1'b0;
   logic       pass_left = 1'b0;
   logic       pass_right = 1'b0;
   logic       phys_step, ball_respawn, serve_dir, winner;
   logic [3:0] score0, score1;
   logic [2:0] game_state;

   int tests = 0;
   int fails = 0;

   pong_game_ctrl #(
      .SERVE_FRAMES(SERVE_N),
      .POINT_FRAMES(POINT_N),
      .WIN_SCORE(WIN_N),
      .SCORE_W(4)
   ) dut (
      .clk_25MHz(clk),
      .reset(reset),
      .vert_blank(vert_blank),
      .start_btn(start_btn),
      .pass_left(pass_left),
      .pass_right(pass_right),
      .phys_step(phys_step),
      .ball_respawn(ball_respawn),
      .serve_dir(serve_dir),
      .score0(score0),
      .score1(score1),
      .game_state(game_state),
      .winner(winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int st;
      int s0;
      int s1;
      int dir;
      int win;
   } ev_t;

   ev_t exp_q[$];

   // Reference model: game-level view (state, scores, frames left in freeze)
   int m_st = S_IDLE, m_s0 = 0, m_s1 = 0, m_dir = 1, m_win = 0, m_left = 0;

   function automatic void push(int kind);
      ev_t e;
      e.kind = kind; e.st = m_st; e.s0 = m_s0; e.s1 = m_s1; e.dir = m_dir; e.win = m_win;
      exp_q.push_back(e);
   endfunction

   function automatic void enter_serve();
      m_st   = S_SERVE;
      m_left = SERVE_N;
      push(EV_STATE);
      push(EV_RESPAWN);
   endfunction

   function automatic void model_frame();
      case (m_st)
         S_PLAY: push(EV_STEP);
         S_SERVE: begin
            m_left--;
            if (m_left == 0) begin
               m_st = S_PLAY;
               push(EV_STATE);
            end
         end
         S_POINT: begin
            m_left--;
            if (m_left == 0) begin
               if (m_s0 == WIN_N || m_s1 == WIN_N) begin
                  m_st  = S_OVER;
                  m_win = (m_s1 == WIN_N) ? 1 : 0;
                  push(EV_STATE);
               end else enter_serve();
            end
         end
         default: ;
      endcase
   endfunction

   function automatic void model_action(bit l, bit r, bit p);
      if (m_st == S_PLAY && (l != r)) begin
         if (r) begin m_s0++; m_dir = 0; end
         else   begin m_s1++; m_dir = 1; end
         m_st   = S_POINT;
         m_left = POINT_N;
         push(EV_STATE);
         return;
      end
      if (p) begin
         case (m_st)
            S_IDLE, S_OVER: begin
               m_s0 = 0; m_s1 = 0; m_win = 0; m_dir = 1;
               enter_serve();
            end
            S_PLAY:   begin m_st = S_PAUSED; push(EV_STATE); end
            S_PAUSED: begin m_st = S_PLAY;   push(EV_STATE); end
            default: ;
         endcase
      end
   endfunction

   // Stimulus
   task automatic do_frame();
      model_frame();
      @(negedge clk);
      vert_blank = 1'b1;
      repeat (4) @(negedge clk);
      vert_blank = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_frames(int n);
      for (int i = 0; i < n; i++) do_frame();
   endtask

   // A press becomes visible inside the DUT two clocks after the button rises;
   // the pass pulse is placed on exactly that cycle when both are requested.
   task automatic action(bit l, bit r, bit p);
      model_action(l, r, p);
      @(negedge clk);
      if (p) begin
         start_btn = 1'b1;
         repeat (2) @(negedge clk);
         pass_left = l; pass_right = r;
         @(negedge clk);
         pass_left = 1'b0; pass_right = 1'b0;
         @(negedge clk);
         start_btn = 1'b0;
         repeat (5) @(negedge clk);
      end else begin
         pass_left = l; pass_right = r;
         @(negedge clk);
         pass_left = 1'b0; pass_right = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every state change, respawn pulse and step pulse is an event
   logic [2:0] prev_state = 3'd0;

   task automatic observe(int kind);
      ev_t a, e;
      a.kind = kind; a.st = int'(game_state); a.s0 = int'(score0); a.s1 = int'(score1);
      a.dir = int'(serve_dir); a.win = int'(winner);
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event @%0t: kind=%0d st=%0d s0=%0d s1=%0d dir=%0d win=%0d",
                  $time, a.kind, a.st, a.s0, a.s1, a.dir, a.win);
         return;
      end
      e = exp_q.pop_front();
      if (kind == EV_STEP) begin
         e.s0 = a.s0; e.s1 = a.s1; e.dir = a.dir; e.win = a.win;
      end
      if (a != e) begin
         fails++;
         $display("FAIL event @%0t: got kind=%0d st=%0d s0=%0d s1=%0d dir=%0d win=%0d expected kind=%0d st=%0d s0=%0d s1=%0d dir=%0d win=%0d",
                  $time, a.kind, a.st, a.s0, a.s1, a.dir, a.win, e.kind, e.st, e.s0, e.s1, e.dir, e.win);
      end
   endtask

   always @(negedge clk) begin
      if (game_state != prev_state) observe(EV_STATE);
      if (ball_respawn)             observe(EV_RESPAWN);
      if (phys_step)                observe(EV_STEP);
      prev_state <= game_state;
   end

   task automatic check_reset_values(string tag);
      check({tag, "_state"},   int'(game_state),   S_IDLE);
      check({tag, "_score0"},  int'(score0),       0);
      check({tag, "_score1"},  int'(score1),       0);
      check({tag, "_dir"},     int'(serve_dir),    1);
      check({tag, "_winner"},  int'(winner),       0);
      check({tag, "_step"},    int'(phys_step),    0);
      check({tag, "_respawn"}, int'(ball_respawn), 0);
   endtask

   task automatic random_game(int max_actions);
      for (int i = 0; i < max_actions; i++) begin
         if (m_st == S_OVER) break;
         if (m_st == S_SERVE || m_st == S_POINT) do_frame();
         else begin
            case ($urandom_range(0, 11))
               6:       action(1'b0, 1'b1, 1'b0);
               7:       action(1'b1, 1'b0, 1'b0);
               8:       action(1'b1, 1'b1, 1'b0);
               9:       action(1'b0, 1'b0, 1'b1);
               10:      action(1'b1, 1'b0, 1'b1);
               11:      action(1'b0, 1'b1, 1'b1);
               default: do_frame();
            endcase
         end
      end
      @(negedge clk);
      check("game_state_end", int'(game_state), m_st);
      check("winner_end",     int'(winner),     m_win);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b0;

      // Idle: frames alone do nothing
      do_frames(3);
      check_reset_values("idle");

      // Start, serve delay, then stepping in play
      action(1'b0, 1'b0, 1'b1);
      do_frames(SERVE_N + 3);
      check("play_state", int'(game_state), S_PLAY);

      // Pause: silent frames, pass ignored, resume
      action(1'b0, 1'b0, 1'b1);
      do_frames(5);
      action(1'b1, 1'b0, 1'b0);
      check("paused_score1", int'(score1), 0);
      action(1'b0, 1'b0, 1'b1);
      do_frames(2);

      // Simultaneous passes: no score
      action(1'b1, 1'b1, 1'b0);
      do_frame();

      // Point to player 0, freeze, reserve
      action(1'b0, 1'b1, 1'b0);
      check("point_score0", int'(score0), 1);
      check("point_dir", int'(serve_dir), 0);
      do_frames(POINT_N + SERVE_N + 2);

      random_game(4000);
      action(1'b0, 1'b0, 1'b1);
      check("restart_score0", int'(score0), 0);
      check("restart_score1", int'(score1), 0);
      check("restart_dir", int'(serve_dir), 1);
      random_game(4000);

      // Reset asynchronously in the middle of a point freeze
      action(1'b0, 1'b0, 1'b1);
      do_frames(SERVE_N);
      action(1'b0, 1'b1, 1'b0);
      do_frames(3);
      m_st = S_IDLE; m_s0 = 0; m_s1 = 0; m_dir = 1; m_win = 0;
      push(EV_STATE);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_reset_values("async_rst");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      do_frames(2);

      repeat (10) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
